fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
// - Parametrised instruction-fetch front end for the multi-cycle CPU.
// - Replaces the single PC register plus single prefetch/instruction register pair.
// - Owns the PC and drives an async-read instruction memory.
// - Buffers fetched words with their PCs in a DEPTH-entry prefetch queue.
// - Hands instructions to decode over a valid/ready handshake; a branch redirect flushes the queue.
// PARAMETERS
// - DATA_W    16  instruction width
// - ADDR_W    8   PC / instruction-memory address width
// - DEPTH     4   prefetch queue entries; power of 2, >=2
// - RESET_PC  0   PC value loaded on reset
// PORTS
// - clk             in   1                    single clock, rising edge
// - rst             in   1                    reset, asynchronous, active-high
// - fetch_en        in   1                    allow a fetch this cycle
// - imem_addr       out  ADDR_W               instruction memory address (= fetch_pc)
// - imem_data       in   DATA_W               instruction memory read data, combinational from imem_addr
// - redirect_valid  in   1                    branch/jump taken: flush and reload PC
// - redirect_pc     in   ADDR_W               new fetch address
// - ir_valid        out  1                    ir_instr/ir_pc hold a valid instruction
// - ir_ready        in   1                    decode accepts the head entry
// - ir_instr        out  DATA_W               head instruction
// - ir_pc           out  ADDR_W               PC of head instruction
// - fetch_pc        out  ADDR_W               next address to fetch
// - q_count         out  $clog2(DEPTH+1)      occupied entries
// - q_full          out  1                    q_count==DEPTH
// BEHAVIOUR
// Reset (async, any cycle):
// - fetch_pc=RESET_PC; q_count=0; read/write pointers=0; storage cleared to 0.
// - ir_valid=0; ir_instr=0; ir_pc=0; q_full=0.
// Handshake:
// - pop = ir_valid & ir_ready.
// - push = fetch_en & ~redirect_valid & (~q_full | pop).
// Push:
// - Writes {imem_data, fetch_pc} at wr_ptr.
// - fetch_pc <= fetch_pc+1, wraps modulo 2^ADDR_W (0xFF -> 0x00 when ADDR_W=8).
// Head and latency:
// - ir_valid = (q_count!=0); ir_instr/ir_pc are driven from the entry at rd_ptr.
// - Fetch-to-ir_valid latency is 1 cycle.
// Occupancy:
// - q_count +1 on push only, -1 on pop only, unchanged on push&pop.
// - Full with pop: push is accepted and q_count stays at DEPTH.
// - Pointers wrap modulo DEPTH.
// Redirect (highest priority):
// - Next cycle: q_count=0, wr_ptr=rd_ptr=0, fetch_pc=redirect_pc.
// - No push in the redirect cycle.
// - A pop in the same cycle counts as a completed transfer; all remaining entries are discarded.
// - ir_valid=0 the cycle after a redirect.
// Stalls and empty:
// - fetch_en=0: no push, fetch_pc holds; the queue still drains via pop.
// - Empty with ir_ready=1: no pop, ir_valid=0, no underflow.
// CONFIGURATION
// - Macro FETCH_BYPASS_EN.
// - Defined:
//   - When q_count==0 & fetch_en & ~redirect_valid: ir_valid=1, ir_instr=imem_data, ir_pc=fetch_pc, combinationally.
//   - If ir_ready is also 1, the word is consumed directly, not pushed, and fetch_pc increments (zero-latency fetch).
//   - If ir_ready=0, the word is pushed normally.
// - Undefined: no bypass; minimum latency is 1 cycle as above.
// TESTING
// - Reset: assert rst mid-run with q_count=3 -> immediately ir_valid=0, q_count=0, fetch_pc=0x00.
// - Stream: imem[k]=0x1000+k, fetch_en=1, ir_ready=1 -> ir_instr 0x1000,0x1001,... with ir_pc 0,1,...; one per cycle after 1-cycle latency.
// - Backpressure, DEPTH=4: ir_ready=0 for 6 cycles -> q_full=1 after 4 pushes, fetch_pc=0x04 and holds.
//   - Then ir_ready=1 -> entries 0..3 pop in order, and a push and pop occur in the same cycle while full.
// - Redirect: q_count=3, redirect_valid=1, redirect_pc=0x40 -> next cycle q_count=0, ir_valid=0, fetch_pc=0x40.
//   - The following cycle ir_pc=0x40.
// - Wrap: redirect_pc=0xFE, streaming -> ir_pc 0xFE,0xFF,0x00,0x01.
// - FETCH_BYPASS_EN: empty queue, fetch_en=1, ir_ready=1 -> ir_valid=1 in the same cycle with ir_instr=imem_data; q_count stays 0.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_unit
//  Description : Instruction-fetch front end. Owns the PC, drives an
//                async-read instruction memory and buffers fetched words
//                with their PCs in a DEPTH-entry prefetch queue. Decode
//                takes the head entry over a valid/ready handshake, and a
//                branch redirect flushes the queue and reloads the PC.
//                Optional feature macro: FETCH_BYPASS_EN. When it is
//                defined, a fetch into an empty queue is presented to
//                decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [DATA_W-1:0]          ir_instr,
    output logic [ADDR_W-1:0]          ir_pc,
    output logic [ADDR_W-1:0]          fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       q_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  c_PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_PC_RST   = ADDR_W'(RESET_PC);

    logic [DATA_W-1:0] r_mem_instr [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_fetch_pc;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_bypass_avail;
    logic w_bypass_take;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);

`ifdef FETCH_BYPASS_EN
    // An empty queue lets the word being fetched go straight to decode.
    assign w_bypass_avail = w_empty & fetch_en & ~redirect_valid;
    assign w_bypass_take  = w_bypass_avail & ir_ready;
`else
    assign w_bypass_avail = 1'b0;
    assign w_bypass_take  = 1'b0;
`endif

    // Queue handshake: a pop needs a stored entry; a bypassed word is never pushed.
    always_comb begin
        w_pop  = ~w_empty & ir_ready;
        w_push = fetch_en & ~redirect_valid & (~w_full | w_pop) & ~w_bypass_take;
    end

    // Head presentation: bypassed word wins when the queue is empty.
    always_comb begin
        ir_valid = ~w_empty | w_bypass_avail;
        ir_instr = r_mem_instr[r_rd_ptr];
        ir_pc    = r_mem_pc[r_rd_ptr];
        if (w_bypass_avail) begin
            ir_instr = imem_data;
            ir_pc    = r_fetch_pc;
        end
    end

    assign imem_addr = r_fetch_pc;
    assign fetch_pc  = r_fetch_pc;
    assign q_count   = r_count;
    assign q_full    = w_full;

    // PC, pointers and occupancy; redirect overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= c_PC_RST;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push || w_bypass_take) begin
                r_fetch_pc <= r_fetch_pc + c_PC_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Entry storage: each push records the fetched word together with its PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_data;
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_unit
//  Description : Directed self-checking bench for fetch_prefetch_unit
//                (DATA_W=16, ADDR_W=8, DEPTH=4, RESET_PC=0).
//                Instruction memory model: imem[a] = 0x1000 + a.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_instr;
    logic [7:0]  ir_pc;
    logic [7:0]  fetch_pc;
    logic [2:0]  q_count;
    logic        q_full;

    int n_vec;
    int n_err;

    fetch_prefetch_unit #(
        .DATA_W  (16),
        .ADDR_W  (8),
        .DEPTH   (4),
        .RESET_PC(0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir_instr      (ir_instr),
        .ir_pc         (ir_pc),
        .fetch_pc      (fetch_pc),
        .q_count       (q_count),
        .q_full        (q_full)
    );

    assign imem_data = 16'h1000 + {8'h00, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flush the queue and load a new PC (one edge).
    task automatic do_redirect(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid got %0b want 0", ir_valid); end
        n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL reset_q_count got %0d want 0", q_count); end
        n_vec++; if (fetch_pc !== 8'h00) begin n_err++; $display("FAIL reset_fetch_pc got %h want 00", fetch_pc); end
        n_vec++; if (q_full !== 1'b0) begin n_err++; $display("FAIL reset_q_full got %0b want 0", q_full); end
        n_vec++; if (ir_instr !== 16'h0000) begin n_err++; $display("FAIL reset_ir_instr got %h want 0000", ir_instr); end
        n_vec++; if (ir_pc !== 8'h00) begin n_err++; $display("FAIL reset_ir_pc got %h want 00", ir_pc); end
    endtask

    task automatic test_stream();
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        #1;
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency ir_valid got %0b want 0", ir_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 8'(k) || ir_instr !== 16'h1000 + 16'(k) || q_count !== 3'd1) begin
                n_err++;
                $display("FAIL stream_%0d got v=%0b pc=%h instr=%h cnt=%0d want v=1 pc=%h instr=%h cnt=1",
                         k, ir_valid, ir_pc, ir_instr, q_count, 8'(k), 16'h1000 + 16'(k));
            end
        end
        fetch_en = 1'b0;
        tick();
        n_vec++; if (q_count !== 3'd0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got cnt=%0d v=%0b want 0 0", q_count, ir_valid); end
        do_redirect(8'h00);
    endtask

    task automatic test_backpressure();
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_vec++;
            if (q_count !== 3'((i < 4) ? i : 4) || fetch_pc !== 8'((i < 4) ? i : 4) || q_full !== (i >= 4)) begin
                n_err++;
                $display("FAIL bp_fill_%0d got cnt=%0d pc=%h full=%0b want cnt=%0d pc=%0d full=%0b",
                         i, q_count, fetch_pc, q_full, (i < 4) ? i : 4, (i < 4) ? i : 4, i >= 4);
            end
        end
        n_vec++; if (ir_pc !== 8'h00 || ir_instr !== 16'h1000) begin n_err++; $display("FAIL bp_head got pc=%h instr=%h want 00 1000", ir_pc, ir_instr); end
        // Full with pop: push of pc 4 accepted alongside pop of pc 0.
        ir_ready = 1'b1;
        tick();
        n_vec++;
        if (q_count !== 3'd4 || q_full !== 1'b1 || ir_pc !== 8'h01 || fetch_pc !== 8'h05) begin
            n_err++;
            $display("FAIL bp_full_pushpop got cnt=%0d full=%0b pc=%h fpc=%h want 4 1 01 05", q_count, q_full, ir_pc, fetch_pc);
        end
        fetch_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (ir_pc !== 8'(1 + k) || ir_instr !== 16'h1001 + 16'(k) || q_count !== 3'(4 - k) || fetch_pc !== 8'h05) begin
                n_err++;
                $display("FAIL bp_drain_%0d got pc=%h instr=%h cnt=%0d fpc=%h want pc=%0d cnt=%0d fpc=05",
                         k, ir_pc, ir_instr, q_count, fetch_pc, 1 + k, 4 - k);
            end
        end
        tick();
        n_vec++; if (ir_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL bp_empty got v=%0b cnt=%0d want 0 0", ir_valid, q_count); end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        repeat (3) tick();
        n_vec++; if (q_count !== 3'd3 || fetch_pc !== 8'h08) begin n_err++; $display("FAIL redir_pre got cnt=%0d fpc=%h want 3 08", q_count, fetch_pc); end
        do_redirect(8'h40);
        n_vec++;
        if (q_count !== 3'd0 || ir_valid !== 1'b0 || fetch_pc !== 8'h40) begin
            n_err++;
            $display("FAIL redir_flush got cnt=%0d v=%0b fpc=%h want 0 0 40", q_count, ir_valid, fetch_pc);
        end
        ir_ready = 1'b1;
        tick();
        n_vec++;
        if (ir_valid !== 1'b1 || ir_pc !== 8'h40 || ir_instr !== 16'h1040) begin
            n_err++;
            $display("FAIL redir_target got v=%0b pc=%h instr=%h want 1 40 1040", ir_valid, ir_pc, ir_instr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        do_redirect(8'hFE);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== exp_pc[k] || ir_instr !== 16'h1000 + {8'h00, exp_pc[k]} ||
                fetch_pc !== exp_pc[k] + 8'h01) begin
                n_err++;
                $display("FAIL wrap_%0d got v=%0b pc=%h instr=%h fpc=%h want pc=%h", k, ir_valid, ir_pc, ir_instr, fetch_pc, exp_pc[k]);
            end
        end
    endtask

    task automatic test_stall_empty();
        fetch_en = 1'b0;
        ir_ready = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (q_count !== 3'd0 || ir_valid !== 1'b0 || fetch_pc !== 8'h02) begin
            n_err++;
            $display("FAIL stall_empty got cnt=%0d v=%0b fpc=%h want 0 0 02", q_count, ir_valid, fetch_pc);
        end
    endtask

    task automatic test_bypass();
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        #1;
`ifdef FETCH_BYPASS_EN
        n_vec++;
        if (ir_valid !== 1'b1 || ir_instr !== 16'h1002 || ir_pc !== 8'h02) begin
            n_err++;
            $display("FAIL bypass_same_cycle got v=%0b instr=%h pc=%h want 1 1002 02", ir_valid, ir_instr, ir_pc);
        end
        tick();
        n_vec++; if (q_count !== 3'd0 || fetch_pc !== 8'h03) begin n_err++; $display("FAIL bypass_no_push got cnt=%0d fpc=%h want 0 03", q_count, fetch_pc); end
`else
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got v=%0b want 0", ir_valid); end
        tick();
        n_vec++; if (q_count !== 3'd1 || ir_pc !== 8'h02 || fetch_pc !== 8'h03) begin n_err++; $display("FAIL no_bypass_push got cnt=%0d pc=%h fpc=%h want 1 02 03", q_count, ir_pc, fetch_pc); end
`endif
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        repeat (3) tick();
        n_vec++; if (q_count !== 3'd3) begin n_err++; $display("FAIL midrst_pre got cnt=%0d want 3", q_count); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (ir_valid !== 1'b0 || q_count !== 3'd0 || fetch_pc !== 8'h00 || q_full !== 1'b0) begin
            n_err++;
            $display("FAIL midrst got v=%0b cnt=%0d fpc=%h full=%0b want 0 0 00 0", ir_valid, q_count, fetch_pc, q_full);
        end
        fetch_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        ir_ready       = 1'b0;
        repeat (2) tick();
        test_reset();
        rst = 1'b0;
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_stall_empty();
        test_bypass();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
